// File: rtl/ctrl_pkg.sv
// ctrl_pkg
// Shared types and constants for the microstep control sequencer:
//   - state_t     : sequencer states (IDLE, T0..T6, HALT)
//   - op_class_t  : coarse instruction class derived from the opcode
//   - OP_* / ALU_*: opcode values and ALU codes used by the immediate forms
//   - classify()  : opcode -> instruction class
//   - imm_alu_op(): immediate opcode -> ALU operation
//   - step_index(): state -> debug step number
package ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_T0   = 4'd1,
        ST_T1   = 4'd2,
        ST_T2   = 4'd3,
        ST_T3   = 4'd4,
        ST_T4   = 4'd5,
        ST_T5   = 4'd6,
        ST_T6   = 4'd7,
        ST_HALT = 4'd8
    } state_t;

    typedef enum logic [3:0] {
        CLS_RRR     = 4'd0,
        CLS_IMM     = 4'd1,
        CLS_MULDIV  = 4'd2,
        CLS_MFHI    = 4'd3,
        CLS_MFLO    = 4'd4,
        CLS_IN      = 4'd5,
        CLS_NOP     = 4'd6,
        CLS_HALT    = 4'd7,
        CLS_ILLEGAL = 4'd8
    } op_class_t;

    // Register-register ALU opcodes occupy a contiguous range.
    localparam logic [4:0] OP_RRR_LO = 5'b00011;
    localparam logic [4:0] OP_RRR_HI = 5'b01010;
    localparam logic [4:0] OP_ADDI   = 5'b01100;
    localparam logic [4:0] OP_ANDI   = 5'b01101;
    localparam logic [4:0] OP_ORI    = 5'b01110;
    localparam logic [4:0] OP_MUL    = 5'b01111;
    localparam logic [4:0] OP_DIV    = 5'b10000;
    localparam logic [4:0] OP_IN     = 5'b10110;
    localparam logic [4:0] OP_MFHI   = 5'b11000;
    localparam logic [4:0] OP_MFLO   = 5'b11001;
    localparam logic [4:0] OP_NOP    = 5'b11010;
    localparam logic [4:0] OP_HALT   = 5'b11011;

    // ALU codes the immediate forms borrow from their RRR counterparts.
    localparam logic [4:0] ALU_ADD   = 5'b00011;
    localparam logic [4:0] ALU_AND   = 5'b00101;
    localparam logic [4:0] ALU_OR    = 5'b00110;

    function automatic op_class_t classify(input logic [4:0] op);
        op_class_t cls;
        if ((op >= OP_RRR_LO) && (op <= OP_RRR_HI)) begin
            cls = CLS_RRR;
        end else begin
            case (op)
                OP_ADDI, OP_ANDI, OP_ORI: cls = CLS_IMM;
                OP_MUL, OP_DIV:           cls = CLS_MULDIV;
                OP_MFHI:                  cls = CLS_MFHI;
                OP_MFLO:                  cls = CLS_MFLO;
                OP_IN:                    cls = CLS_IN;
                OP_NOP:                   cls = CLS_NOP;
                OP_HALT:                  cls = CLS_HALT;
                default:                  cls = CLS_ILLEGAL;
            endcase
        end
        return cls;
    endfunction

    function automatic logic [4:0] imm_alu_op(input logic [4:0] op);
        logic [4:0] code;
        case (op)
            OP_ADDI: code = ALU_ADD;
            OP_ANDI: code = ALU_AND;
            OP_ORI:  code = ALU_OR;
            default: code = 5'b00000;
        endcase
        return code;
    endfunction

    // IDLE and HALT report step 0 so the debug port never shows a stale value.
    function automatic logic [2:0] step_index(input state_t s);
        logic [2:0] idx;
        case (s)
            ST_T0:   idx = 3'd0;
            ST_T1:   idx = 3'd1;
            ST_T2:   idx = 3'd2;
            ST_T3:   idx = 3'd3;
            ST_T4:   idx = 3'd4;
            ST_T5:   idx = 3'd5;
            ST_T6:   idx = 3'd6;
            default: idx = 3'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/reg_sel_dec.sv
// reg_sel_dec
// 4-to-16 one-hot decoder with enable, used to turn a GPR field into
// a set of per-register strobes.
//   en_i      : 1 = drive the selected bit, 0 = all outputs low
//   sel_i[3:0]: register index (R0..R15)
//   onehot_o  : one-hot (or all-zero) strobe vector
module reg_sel_dec (
    input  logic        en_i,
    input  logic [3:0]  sel_i,
    output logic [15:0] onehot_o
);

    // Decode the index into a single strobe when enabled.
    always_comb begin
        onehot_o = 16'h0000;
        if (en_i) begin
            onehot_o[sel_i] = 1'b1;
        end else begin
            onehot_o = 16'h0000;
        end
    end

endmodule

// File: rtl/ctrl_step_seq.sv
// ctrl_step_seq
// Microstep control sequencer for the 32-bit single-bus datapath. Each
// instruction runs as a T0..T6 step sequence; every step drives at most one
// bus-source strobe plus the matching load, ALU and memory controls.
// Outputs are decoded from the state register and ir (MDRin also from
// mem_done) so the bus source encoder sees them in the same cycle.
// Ports:
//   clock, reset           : rising-edge clock, synchronous active-high reset
//   start                  : leave IDLE and begin the first fetch
//   ir[31:0]               : instruction (op[31:27] ra[26:23] rb[22:19] rc[18:15])
//   mem_done               : memory read data valid
//   r_out/r_in[15:0]       : GPR out-strobes / load strobes (one-hot)
//   HIout..Cout            : remaining bus-source strobes
//   PCin..LOin             : register loads
//   inc_pc, read, alu_op   : ALU PC+1 select, memory read, ALU operation
//   step, done, illegal, halted : debug step, end-of-instruction, bad opcode, halt
module ctrl_step_seq
    import ctrl_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] ir,
    input  logic        mem_done,
    output logic [15:0] r_out,
    output logic        HIout,
    output logic        LOout,
    output logic        ZHighout,
    output logic        ZLowout,
    output logic        PCout,
    output logic        MDRout,
    output logic        InPortout,
    output logic        Cout,
    output logic [15:0] r_in,
    output logic        PCin,
    output logic        IRin,
    output logic        MARin,
    output logic        MDRin,
    output logic        Yin,
    output logic        Zin,
    output logic        HIin,
    output logic        LOin,
    output logic        inc_pc,
    output logic        read,
    output logic [4:0]  alu_op,
    output logic [2:0]  step,
    output logic        done,
    output logic        illegal,
    output logic        halted
);

    state_t     state_q;
    state_t     state_d;
    op_class_t  cls_s;
    logic [4:0] opcode_s;
    logic [3:0] ra_s;
    logic [3:0] rb_s;
    logic [3:0] rc_s;
    logic       rout_en_s;
    logic [3:0] rout_sel_s;
    logic       rin_en_s;
    logic       unused_ir_s;

    assign opcode_s    = ir[31:27];
    assign ra_s        = ir[26:23];
    assign rb_s        = ir[22:19];
    assign rc_s        = ir[18:15];
    // Low IR bits carry immediates for the datapath, not for sequencing.
    assign unused_ir_s = ^ir[14:0];
    assign cls_s       = classify(opcode_s);
    assign step        = step_index(state_q);

    // Source-side GPR strobe: rb in T3, rc in T4.
    reg_sel_dec u_rout_dec (
        .en_i     (rout_en_s),
        .sel_i    (rout_sel_s),
        .onehot_o (r_out)
    );

    // Destination-side GPR strobe: always ra.
    reg_sel_dec u_rin_dec (
        .en_i     (rin_en_s),
        .sel_i    (ra_s),
        .onehot_o (r_in)
    );

    // Next-state selection for the step sequence.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_T0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_T0: state_d = ST_T1;
            ST_T1: begin
                if (mem_done) begin
                    state_d = ST_T2;
                end else begin
                    state_d = ST_T1;
                end
            end
            ST_T2: state_d = ST_T3;
            ST_T3: begin
                case (cls_s)
                    CLS_RRR, CLS_IMM, CLS_MULDIV: state_d = ST_T4;
                    CLS_HALT:                     state_d = ST_HALT;
                    default:                      state_d = ST_T0;
                endcase
            end
            ST_T4: begin
                case (cls_s)
                    CLS_RRR, CLS_IMM, CLS_MULDIV: state_d = ST_T5;
                    default:                      state_d = ST_T0;
                endcase
            end
            ST_T5: begin
                if (cls_s == CLS_MULDIV) begin
                    state_d = ST_T6;
                end else begin
                    state_d = ST_T0;
                end
            end
            ST_T6:   state_d = ST_T0;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
    end

    // State register; reset wins over everything, including HALT and T1 waits.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Control decode for the current step; defaults keep every strobe low.
    always_comb begin
        HIout      = 1'b0;
        LOout      = 1'b0;
        ZHighout   = 1'b0;
        ZLowout    = 1'b0;
        PCout      = 1'b0;
        MDRout     = 1'b0;
        InPortout  = 1'b0;
        Cout       = 1'b0;
        PCin       = 1'b0;
        IRin       = 1'b0;
        MARin      = 1'b0;
        MDRin      = 1'b0;
        Yin        = 1'b0;
        Zin        = 1'b0;
        HIin       = 1'b0;
        LOin       = 1'b0;
        inc_pc     = 1'b0;
        read       = 1'b0;
        alu_op     = 5'b00000;
        done       = 1'b0;
        illegal    = 1'b0;
        halted     = 1'b0;
        rout_en_s  = 1'b0;
        rout_sel_s = rb_s;
        rin_en_s   = 1'b0;
        case (state_q)
            ST_T0: begin
                PCout  = 1'b1;
                MARin  = 1'b1;
                inc_pc = 1'b1;
                Zin    = 1'b1;
            end
            ST_T1: begin
                ZLowout = 1'b1;
                PCin    = 1'b1;
                read    = 1'b1;
                // MDR captures only on the cycle the memory returns data.
                MDRin   = mem_done;
            end
            ST_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            ST_T3: begin
                case (cls_s)
                    CLS_RRR, CLS_IMM, CLS_MULDIV: begin
                        rout_en_s  = 1'b1;
                        rout_sel_s = rb_s;
                        Yin        = 1'b1;
                    end
                    CLS_MFHI: begin
                        HIout    = 1'b1;
                        rin_en_s = 1'b1;
                        done     = 1'b1;
                    end
                    CLS_MFLO: begin
                        LOout    = 1'b1;
                        rin_en_s = 1'b1;
                        done     = 1'b1;
                    end
                    CLS_IN: begin
                        InPortout = 1'b1;
                        rin_en_s  = 1'b1;
                        done      = 1'b1;
                    end
                    CLS_NOP, CLS_HALT: begin
                        done = 1'b1;
                    end
                    default: begin
                        illegal = 1'b1;
                    end
                endcase
            end
            ST_T4: begin
                case (cls_s)
                    CLS_RRR, CLS_MULDIV: begin
                        rout_en_s  = 1'b1;
                        rout_sel_s = rc_s;
                        Zin        = 1'b1;
                        alu_op     = opcode_s;
                    end
                    CLS_IMM: begin
                        Cout   = 1'b1;
                        Zin    = 1'b1;
                        alu_op = imm_alu_op(opcode_s);
                    end
                    default: begin
                        alu_op = 5'b00000;
                    end
                endcase
            end
            ST_T5: begin
                ZLowout = 1'b1;
                if (cls_s == CLS_MULDIV) begin
                    LOin = 1'b1;
                end else begin
                    rin_en_s = 1'b1;
                    done     = 1'b1;
                end
            end
            ST_T6: begin
                ZHighout = 1'b1;
                HIin     = 1'b1;
                done     = 1'b1;
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: begin
                halted = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_ctrl_step_seq.sv
module tb_ctrl_step_seq;

    logic        clock;
    logic        reset;
    logic        start;
    logic [31:0] ir;
    logic        mem_done;
    logic [15:0] r_out;
    logic        HIout, LOout, ZHighout, ZLowout, PCout, MDRout, InPortout, Cout;
    logic [15:0] r_in;
    logic        PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin;
    logic        inc_pc, read;
    logic [4:0]  alu_op;
    logic [2:0]  step;
    logic        done, illegal, halted;

    ctrl_step_seq dut (
        .clock(clock), .reset(reset), .start(start), .ir(ir), .mem_done(mem_done),
        .r_out(r_out), .HIout(HIout), .LOout(LOout), .ZHighout(ZHighout),
        .ZLowout(ZLowout), .PCout(PCout), .MDRout(MDRout), .InPortout(InPortout),
        .Cout(Cout), .r_in(r_in), .PCin(PCin), .IRin(IRin), .MARin(MARin),
        .MDRin(MDRin), .Yin(Yin), .Zin(Zin), .HIin(HIin), .LOin(LOin),
        .inc_pc(inc_pc), .read(read), .alu_op(alu_op), .step(step),
        .done(done), .illegal(illegal), .halted(halted)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [15:0] r_out;
        logic hi, lo, zh, zl, pc, mdr, inp, c;
        logic [15:0] r_in;
        logic pcin, irin, marin, mdrin, yin, zin, hiin, loin;
        logic inc, rd;
        logic [4:0] alu;
        logic [2:0] step;
        logic done, ill, halted;
    } out_t;

    typedef struct {
        logic [4:0]  op;
        logic [3:0]  ra, rb, rc;
        int          wt;
        int          len;
        logic [15:0] t3, t4;
        logic [4:0]  alu;
        logic [15:0] rin;
        logic        ill;
    } vec_t;

    int checks = 0;
    int errors = 0;

    int          obs_len;
    logic        obs_end;
    logic [15:0] obs_t3, obs_t4, obs_rin;
    logic [4:0]  obs_alu;
    logic        obs_ill;

    function automatic out_t sample();
        out_t a;
        a = {r_out, HIout, LOout, ZHighout, ZLowout, PCout, MDRout, InPortout, Cout,
             r_in, PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin,
             inc_pc, read, alu_op, step, done, illegal, halted};
        return a;
    endfunction

    // Instruction length in steps (T0 onwards) with no memory wait.
    function automatic int instr_steps(input logic [4:0] op);
        if ((op >= 5'd3 && op <= 5'd10) || op == 5'd12 || op == 5'd13 || op == 5'd14)
            return 6;
        else if (op == 5'd15 || op == 5'd16)
            return 7;
        else
            return 4;
    endfunction

    // Reference: expected controls for a phase (0..6 = T0..T6, 7 = IDLE, 8 = HALT).
    function automatic out_t model(input int ph, input logic [31:0] iv, input logic md);
        out_t e;
        logic [4:0] op;
        logic [3:0] ra, rb, rc;
        bit arith, imm, muldiv;
        e = '0;
        op = iv[31:27]; ra = iv[26:23]; rb = iv[22:19]; rc = iv[18:15];
        muldiv = (op == 5'd15 || op == 5'd16);
        imm    = (op == 5'd12 || op == 5'd13 || op == 5'd14);
        arith  = (op >= 5'd3 && op <= 5'd10);
        if (ph <= 6) e.step = 3'(ph);
        case (ph)
            0: begin e.pc = 1; e.marin = 1; e.inc = 1; e.zin = 1; end
            1: begin e.zl = 1; e.pcin = 1; e.rd = 1; e.mdrin = md; end
            2: begin e.mdr = 1; e.irin = 1; end
            3: begin
                if (arith || imm || muldiv) begin e.r_out = 16'd1 << rb; e.yin = 1; end
                else if (op == 5'd24) begin e.hi = 1; e.r_in = 16'd1 << ra; e.done = 1; end
                else if (op == 5'd25) begin e.lo = 1; e.r_in = 16'd1 << ra; e.done = 1; end
                else if (op == 5'd22) begin e.inp = 1; e.r_in = 16'd1 << ra; e.done = 1; end
                else if (op == 5'd26 || op == 5'd27) e.done = 1;
                else e.ill = 1;
            end
            4: begin
                e.zin = 1;
                if (imm) begin
                    e.c = 1;
                    e.alu = (op == 5'd12) ? 5'd3 : (op == 5'd13) ? 5'd5 : 5'd6;
                end else begin
                    e.r_out = 16'd1 << rc; e.alu = op;
                end
            end
            5: begin
                e.zl = 1;
                if (muldiv) e.loin = 1;
                else begin e.r_in = 16'd1 << ra; e.done = 1; end
            end
            6: begin e.zh = 1; e.hiin = 1; e.done = 1; end
            8: e.halted = 1;
            default: e = '0;
        endcase
        return e;
    endfunction

    // One cycle: compare at the falling edge, then advance past the rising edge.
    task automatic cyc(input int ph, input string name);
        out_t e, a;
        e = model(ph, ir, mem_done);
        @(negedge clock);
        a = sample();
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s ph=%0d: got %h expected %h", name, ph, a, e);
        end
        checks++;
        if ($countones({a.r_out, a.hi, a.lo, a.zh, a.zl, a.pc, a.mdr, a.inp, a.c}) > 1) begin
            errors++;
            $display("FAIL onehot %s: got strobes %h expected at most one", name, a[60:37]);
        end
        if (!obs_end) obs_len++;
        if (ph == 3) obs_t3 = a.r_out;
        if (ph == 4) begin obs_t4 = a.r_out; obs_alu = a.alu; end
        if (!obs_end && (a.done || a.ill)) begin
            obs_end = 1'b1; obs_rin = a.r_in; obs_ill = a.ill;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc(7, "idle_start");
        start = 1'b0;
    endtask

    // Full instruction from T0 with wt wait cycles in T1; start toggles randomly.
    task automatic run_instr(input logic [4:0] op, input logic [3:0] ra, rb, rc,
                             input int wt, input string name);
        ir = {op, ra, rb, rc, 15'($urandom)};
        obs_len = 0; obs_end = 1'b0; obs_t3 = '0; obs_t4 = '0;
        obs_alu = '0; obs_rin = '0; obs_ill = 1'b0;
        start = 1'($urandom); mem_done = 1'($urandom);
        cyc(0, name);
        for (int w = 0; w < wt; w++) begin
            mem_done = 1'b0; start = 1'($urandom);
            cyc(1, name);
        end
        mem_done = 1'b1;
        cyc(1, name);
        mem_done = 1'($urandom);
        cyc(2, name);
        for (int p = 3; p < instr_steps(op); p++) begin
            start = 1'($urandom); mem_done = 1'($urandom);
            cyc(p, name);
        end
    endtask

    vec_t tbl [11];

    initial begin
        tbl[0]  = '{5'd3,  4'd3,  4'd1,  4'd2,  2, 8, 16'h0002, 16'h0004, 5'd3,  16'h0008, 1'b0};
        tbl[1]  = '{5'd14, 4'd5,  4'd4,  4'd0,  0, 6, 16'h0010, 16'h0000, 5'd6,  16'h0020, 1'b0};
        tbl[2]  = '{5'd15, 4'd1,  4'd2,  4'd3,  0, 7, 16'h0004, 16'h0008, 5'd15, 16'h0000, 1'b0};
        tbl[3]  = '{5'd24, 4'd7,  4'd0,  4'd0,  0, 4, 16'h0000, 16'h0000, 5'd0,  16'h0080, 1'b0};
        tbl[4]  = '{5'd31, 4'd2,  4'd2,  4'd2,  0, 4, 16'h0000, 16'h0000, 5'd0,  16'h0000, 1'b1};
        tbl[5]  = '{5'd13, 4'd0,  4'd15, 4'd9,  0, 6, 16'h8000, 16'h0000, 5'd5,  16'h0001, 1'b0};
        tbl[6]  = '{5'd16, 4'd15, 4'd0,  4'd15, 1, 8, 16'h0001, 16'h8000, 5'd16, 16'h0000, 1'b0};
        tbl[7]  = '{5'd12, 4'd2,  4'd3,  4'd1,  0, 6, 16'h0008, 16'h0000, 5'd3,  16'h0004, 1'b0};
        tbl[8]  = '{5'd22, 4'd9,  4'd1,  4'd1,  0, 4, 16'h0000, 16'h0000, 5'd0,  16'h0200, 1'b0};
        tbl[9]  = '{5'd26, 4'd4,  4'd4,  4'd4,  0, 4, 16'h0000, 16'h0000, 5'd0,  16'h0000, 1'b0};
        tbl[10] = '{5'd10, 4'd4,  4'd5,  4'd6,  0, 6, 16'h0020, 16'h0040, 5'd10, 16'h0010, 1'b0};

        obs_end = 1'b1; obs_len = 0;
        reset = 1'b1; start = 1'b0; mem_done = 1'b0; ir = '0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        cyc(7, "reset_idle");
        do_start();

        // Reset while T1 is waiting on memory.
        ir = {5'd3, 4'd3, 4'd1, 4'd2, 15'd0};
        mem_done = 1'b0;
        cyc(0, "midT1");
        cyc(1, "midT1");
        reset = 1'b1;
        cyc(1, "midT1");
        reset = 1'b0; start = 1'b0;
        cyc(7, "midT1_idle");
        cyc(7, "midT1_idle2");
        do_start();

        // Directed table.
        foreach (tbl[i]) begin
            run_instr(tbl[i].op, tbl[i].ra, tbl[i].rb, tbl[i].rc, tbl[i].wt, "table");
            checks++;
            if (obs_len != tbl[i].len) begin
                errors++; $display("FAIL tbl%0d_len: got %0d expected %0d", i, obs_len, tbl[i].len);
            end
            checks++;
            if (obs_t3 !== tbl[i].t3) begin
                errors++; $display("FAIL tbl%0d_t3: got %h expected %h", i, obs_t3, tbl[i].t3);
            end
            checks++;
            if (obs_t4 !== tbl[i].t4 || obs_alu !== tbl[i].alu) begin
                errors++; $display("FAIL tbl%0d_t4: got %h/%h expected %h/%h", i, obs_t4, obs_alu, tbl[i].t4, tbl[i].alu);
            end
            checks++;
            if (obs_rin !== tbl[i].rin || obs_ill !== tbl[i].ill) begin
                errors++; $display("FAIL tbl%0d_end: got %h/%b expected %h/%b", i, obs_rin, obs_ill, tbl[i].rin, tbl[i].ill);
            end
        end

        // Random instruction stream, back to back.
        for (int n = 0; n < 60; n++) begin
            logic [4:0] op;
            op = 5'($urandom_range(0, 31));
            if (op == 5'd27) op = 5'd26;
            run_instr(op, 4'($urandom), 4'($urandom), 4'($urandom), $urandom_range(0, 3), "random");
        end

        // Halt, stay halted with start pulsing, leave only by reset.
        run_instr(5'd27, 4'd0, 4'd0, 4'd0, 0, "halt");
        for (int k = 0; k < 20; k++) begin
            start = 1'($urandom); mem_done = 1'($urandom);
            cyc(8, "halted");
        end
        reset = 1'b1;
        cyc(8, "halt_reset");
        reset = 1'b0; start = 1'b0;
        cyc(7, "after_halt_idle");
        do_start();
        run_instr(5'd3, 4'd3, 4'd1, 4'd2, 0, "post_halt_add");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
